// File: rtl/axi_lite_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_lite_pkg: AXI4-Lite bus types, response codes and slave FSM states.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package axi_lite_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;
  typedef logic [1:0]        resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_lite_if: AXI4-Lite five-channel bundle with master/slave modports.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface
`default_nettype wire

// File: rtl/axi_lite_reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_lite_reg_bank: register storage with byte-strobe merge, write pulses |
// | and combinational read mux. Revision: 1.0                                |
// +--------------------------------------------------------------------------+
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                             aclk,
  input  logic                             areset_n,
  input  logic                             we,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  data_t                            wr_data,
  input  strb_t                            wr_strb,
  input  logic [IDX_W-1:0]                 rd_idx,
  output data_t                            rd_data,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  output logic [NUM_REGS-1:0]              wr_pulse
);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      regs     <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (we) begin
        if (|wr_strb) wr_pulse[wr_idx] <= 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Reads see the pre-commit value when a write lands on the same edge.
  assign rd_data = regs[rd_idx];

endmodule
`default_nettype wire

// File: rtl/axi_lite_slave_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_lite_slave_regs: AXI4-Lite slave into a register bank. Define        |
// | AXI_LITE_SLVERR_EN for SLVERR on out-of-range access. Revision: 1.0      |
// +--------------------------------------------------------------------------+
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                             aclk,
  input  logic                             areset_n,
  axi_lite_if.slave                        s_axi,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  reg_o,
  output logic [NUM_REGS-1:0]              wr_pulse_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

`ifdef AXI_LITE_SLVERR_EN
  localparam resp_t OOR_RESP = RESP_SLVERR;
`else
  localparam resp_t OOR_RESP = RESP_OKAY;
`endif

  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;

  logic  awready, wready, bvalid, arready, rvalid;
  logic  awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
  resp_t bresp, rresp;
  data_t rdata;

  addr_t aw_addr_q;
  data_t w_data_q;
  strb_t w_strb_q;

  logic  aw_hs, w_hs, ar_hs, commit;
  addr_t cm_addr;
  data_t cm_data;
  strb_t cm_strb;
  logic  cm_in_range, ar_in_range;
  data_t bank_rdata;

  function automatic logic in_range(input addr_t a);
    return (a >> 2) < addr_t'(NUM_REGS);
  endfunction

  assign aw_hs       = s_axi.awvalid && awready;
  assign w_hs        = s_axi.wvalid && wready;
  assign ar_hs       = s_axi.arvalid && arready;
  assign cm_in_range = in_range(cm_addr);
  assign ar_in_range = in_range(s_axi.araddr);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_state  <= W_IDLE;
      rd_state  <= R_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      rresp     <= RESP_OKAY;
      rdata     <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      awready  <= awready_d;
      wready   <= wready_d;
      bvalid   <= bvalid_d;
      arready  <= arready_d;
      rvalid   <= rvalid_d;
      if (aw_hs) aw_addr_q <= s_axi.awaddr;
      if (w_hs) begin
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
      if (commit) bresp <= cm_in_range ? RESP_OKAY : OOR_RESP;
      if (ar_hs) begin
        rdata <= ar_in_range ? bank_rdata : '0;
        rresp <= ar_in_range ? RESP_OKAY : OOR_RESP;
      end
    end
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_next = W_RESP;
        else if (aw_hs)    wr_next = W_ADDR;
        else if (w_hs)     wr_next = W_DATA;
      end
      W_ADDR:  if (w_hs)         wr_next = W_RESP;
      W_DATA:  if (aw_hs)        wr_next = W_RESP;
      W_RESP:  if (s_axi.bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase

    rd_next = rd_state;
    unique case (rd_state)
      R_IDLE:  if (ar_hs)        rd_next = R_DATA;
      R_DATA:  if (s_axi.rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Ready/valid flops are loaded from the next state so every output is registered.
  always_comb begin
    awready_d = (wr_next == W_IDLE) || (wr_next == W_DATA);
    wready_d  = (wr_next == W_IDLE) || (wr_next == W_ADDR);
    bvalid_d  = (wr_next == W_RESP);
    arready_d = (rd_next == R_IDLE);
    rvalid_d  = (rd_next == R_DATA);
    commit    = (wr_state != W_RESP) && (wr_next == W_RESP);
    cm_addr   = (wr_state == W_ADDR) ? aw_addr_q : s_axi.awaddr;
    cm_data   = (wr_state == W_DATA) ? w_data_q  : s_axi.wdata;
    cm_strb   = (wr_state == W_DATA) ? w_strb_q  : s_axi.wstrb;
  end

  axi_lite_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .aclk     (aclk),
    .areset_n (areset_n),
    .we       (commit && cm_in_range),
    .wr_idx   (cm_addr[2 +: IDX_W]),
    .wr_data  (cm_data),
    .wr_strb  (cm_strb),
    .rd_idx   (s_axi.araddr[2 +: IDX_W]),
    .rd_data  (bank_rdata),
    .regs     (reg_o),
    .wr_pulse (wr_pulse_o)
  );

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = bresp;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rresp   = rresp;
  assign s_axi.rdata   = rdata;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_lite_slave_regs: randomized AXI4-Lite traffic against a register  |
// | array model, plus directed corner cases. Revision: 1.0                   |
// +--------------------------------------------------------------------------+
module tb_axi_lite_slave_regs;
  import axi_lite_pkg::*;

  localparam int NUM_REGS = 16;
  typedef logic [511:0] wide_t;

`ifdef AXI_LITE_SLVERR_EN
  localparam resp_t EXP_OOR = 2'b10;
`else
  localparam resp_t EXP_OOR = 2'b00;
`endif

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  logic [NUM_REGS-1:0][31:0] reg_o;
  logic [NUM_REGS-1:0]       wr_pulse_o;

  axi_lite_if bus ();

  axi_lite_slave_regs #(.NUM_REGS(NUM_REGS)) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .s_axi      (bus),
    .reg_o      (reg_o),
    .wr_pulse_o (wr_pulse_o)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [NUM_REGS];

  task automatic check_eq(input string tag, input wide_t obs, input wide_t exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_ok(input addr_t a);
    return (a / 4) < NUM_REGS;
  endfunction

  function automatic wide_t model_vec();
    wide_t v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  task automatic axi_write(input addr_t a, input data_t d, input strb_t s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    int cyc = 0;
    logic [31:0] mask = '0;
    logic [NUM_REGS-1:0] exp_pulse = '0;
    resp_t exp_resp;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.awaddr  = a;
      bus.wdata   = d;
      bus.wstrb   = s;
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      @(posedge aclk);
      @(negedge aclk);
      aw_done |= aw_now;
      w_done  |= w_now;
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check_eq("wr_handshake", wide_t'(aw_done && w_done), wide_t'(1'b1));
    if (!(aw_done && w_done)) return;
    for (int b = 0; b < 4; b++) if (s[b]) mask[8*b +: 8] = 8'hFF;
    exp_resp = addr_ok(a) ? 2'b00 : EXP_OOR;
    if (addr_ok(a)) begin
      model[a/4] = (model[a/4] & ~mask) | (d & mask);
      if (s != 0) exp_pulse[a/4] = 1'b1;
    end
    check_eq("bvalid_rise", wide_t'(bus.bvalid), wide_t'(1'b1));
    check_eq("bresp", wide_t'(bus.bresp), wide_t'(exp_resp));
    check_eq("wr_pulse", wide_t'(wr_pulse_o), wide_t'(exp_pulse));
    check_eq("reg_o", wide_t'(reg_o), model_vec());
    bus.bready = 1'b0;
    for (int i = 0; i < b_dly; i++) begin
      @(negedge aclk);
      check_eq("bvalid_hold", wide_t'(bus.bvalid), wide_t'(1'b1));
      check_eq("bresp_hold", wide_t'(bus.bresp), wide_t'(exp_resp));
      check_eq("aw_w_blocked", wide_t'({bus.awready, bus.wready}), wide_t'(2'b00));
    end
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    check_eq("bvalid_fall", wide_t'(bus.bvalid), wide_t'(1'b0));
    check_eq("aw_w_reopen", wide_t'({bus.awready, bus.wready}), wide_t'(2'b11));
    check_eq("wr_pulse_1cyc", wide_t'(wr_pulse_o), wide_t'(0));
  endtask

  task automatic axi_read(input addr_t a, input int ar_dly, input int r_dly);
    int cyc = 0;
    data_t exp_data = addr_ok(a) ? model[a/4] : 32'h0;
    resp_t exp_resp = addr_ok(a) ? 2'b00 : EXP_OOR;
    repeat (ar_dly) @(negedge aclk);
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    while (!bus.arready && cyc < 20) begin
      @(negedge aclk);
      cyc++;
    end
    check_eq("ar_handshake", wide_t'(bus.arready), wide_t'(1'b1));
    if (!bus.arready) begin
      bus.arvalid = 1'b0;
      return;
    end
    @(negedge aclk);
    bus.arvalid = 1'b0;
    check_eq("rvalid_rise", wide_t'(bus.rvalid), wide_t'(1'b1));
    check_eq("rdata", wide_t'(bus.rdata), wide_t'(exp_data));
    check_eq("rresp", wide_t'(bus.rresp), wide_t'(exp_resp));
    for (int i = 0; i < r_dly; i++) begin
      @(negedge aclk);
      check_eq("rvalid_hold", wide_t'(bus.rvalid), wide_t'(1'b1));
      check_eq("rdata_hold", wide_t'(bus.rdata), wide_t'(exp_data));
      check_eq("ar_blocked", wide_t'(bus.arready), wide_t'(1'b0));
    end
    bus.rready = 1'b1;
    @(negedge aclk);
    bus.rready = 1'b0;
    check_eq("rvalid_fall", wide_t'(bus.rvalid), wide_t'(1'b0));
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_valids"}, wide_t'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}),
             wide_t'(0));
    check_eq({tag, "_resp_data"}, wide_t'({bus.bresp, bus.rresp, bus.rdata}), wide_t'(0));
    check_eq({tag, "_regs"}, wide_t'(reg_o), wide_t'(0));
    check_eq({tag, "_pulse"}, wide_t'(wr_pulse_o), wide_t'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    addr_t a;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset held for 3 cycles, then release.
    repeat (3) @(negedge aclk);
    check_idle_zero("reset");
    areset_n = 1'b1;
    @(negedge aclk);
    check_eq("post_reset_ready", wide_t'({bus.awready, bus.wready, bus.arready}), wide_t'(3'b111));

    // Simultaneous AW/W write, then read back.
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check_eq("dir_reg1", wide_t'(reg_o[1]), wide_t'(32'hDEADBEEF));
    axi_read(32'h04, 0, 0);

    // AW first, W three cycles later, partial strobe.
    axi_write(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(32'h08, 32'h00001234, 4'b0011, 0, 3, 0);
    check_eq("dir_reg2_merge", wide_t'(reg_o[2]), wide_t'(32'hFFFF1234));

    // W first, then AW; bready held low 5 cycles.
    axi_write(32'h14, 32'hA5A5_0F0F, 4'b1100, 2, 0, 5);

    // Zero strobe: no change, no pulse.
    axi_write(32'h04, 32'h0, 4'h0, 0, 0, 1);
    check_eq("dir_zero_strb", wide_t'(reg_o[1]), wide_t'(32'hDEADBEEF));

    // Out-of-range write and read.
    axi_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    axi_read(32'h40, 0, 2);

    // Read captures pre-commit value when AR and write commit share an edge.
    axi_write(32'h0C, 32'h11, 4'hF, 0, 0, 0);
    bus.awaddr = 32'h0C; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 32'h0C; bus.arvalid = 1'b1;
    check_eq("same_edge_ready", wide_t'({bus.awready, bus.wready, bus.arready}), wide_t'(3'b111));
    @(negedge aclk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    model[3] = 32'h55;
    check_eq("same_edge_rdata", wide_t'(bus.rdata), wide_t'(32'h11));
    check_eq("same_edge_valids", wide_t'({bus.bvalid, bus.rvalid}), wide_t'(2'b11));
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    axi_read(32'h0C, 0, 0);

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom_range(16, 1023) * 4 + $urandom_range(0, 3);
      else a = $urandom_range(0, NUM_REGS - 1) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset in the middle of a pending write response.
    bus.awaddr = 32'h00; bus.wdata = 32'h1357_9BDF; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check_eq("midrst_pending", wide_t'(bus.bvalid), wide_t'(1'b1));
    #2 areset_n = 1'b0;
    #1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    check_idle_zero("midrst");
    @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);
    check_eq("midrst_ready", wide_t'({bus.awready, bus.wready, bus.arready, bus.bvalid}),
             wide_t'(4'b1110));
    axi_read(32'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
